// File: rtl/riscp_pkg.sv
// Shared definitions for the memory-access stage: opcode classes, instruction
// field positions, default geometry and the stage FSM encoding.
package riscp_pkg;

  // Opcode classes as presented on Inst_Type_In
  localparam logic [4:0] TYPE_IMMEDIATE = 5'b00100;
  localparam logic [4:0] TYPE_REG_REG   = 5'b01100;
  localparam logic [4:0] TYPE_LOAD      = 5'b00000;
  localparam logic [4:0] TYPE_STORE     = 5'b01000;
  localparam logic [4:0] TYPE_BRANCH    = 5'b11000;
  localparam logic [4:0] TYPE_MAC       = 5'b11111;

  // Instruction field positions
  localparam int RD_HI     = 11;
  localparam int RD_LO     = 7;
  localparam int FUNCT3_HI = 14;
  localparam int FUNCT3_LO = 12;
  localparam int FUNCT7_HI = 31;
  localparam int FUNCT7_LO = 25;

  // Default geometry
  localparam int ADDR_W_DEF      = 8;
  localparam int MEM_LATENCY_DEF = 2;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  // Destination register field of an instruction word
  function automatic logic [4:0] get_rd(input logic [31:0] inst);
    return inst[RD_HI:RD_LO];
  endfunction

  // True for classes that go through data memory
  function automatic logic is_mem_type(input logic [4:0] typ);
    return (typ == TYPE_LOAD) || (typ == TYPE_STORE);
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Execute -> memory -> write-back bundle of the memory-access stage.
interface mem_stage_if;
  logic        Valid_In;
  logic [31:0] Inst_In;
  logic [31:0] Result_In;
  logic [31:0] Operand_B_In;
  logic [4:0]  Inst_Type_In;
  logic        isBranchTaken_In;
  logic        Stall_Out;
  logic        Valid_Out;
  logic [31:0] Inst_Out;
  logic [4:0]  Inst_Type_Out;
  logic [31:0] Result_Out;
  logic [31:0] Load_Data_Out;
  logic [4:0]  Rd_Out;
  logic        RegWrite_Out;
  logic        isBranchTaken_Out;
  logic        Misaligned_Out;

  // Upstream/observer side
  modport master (
    output Valid_In, Inst_In, Result_In, Operand_B_In, Inst_Type_In, isBranchTaken_In,
    input  Stall_Out, Valid_Out, Inst_Out, Inst_Type_Out, Result_Out, Load_Data_Out,
           Rd_Out, RegWrite_Out, isBranchTaken_Out, Misaligned_Out
  );

  // Memory stage side
  modport slave (
    input  Valid_In, Inst_In, Result_In, Operand_B_In, Inst_Type_In, isBranchTaken_In,
    output Stall_Out, Valid_Out, Inst_Out, Inst_Type_Out, Result_Out, Load_Data_Out,
           Rd_Out, RegWrite_Out, isBranchTaken_Out, Misaligned_Out
  );
endinterface

// File: rtl/mem_stage_data_mem.sv
// Single-port word-addressed data memory: synchronous write, read sampled by
// the owner at commit. Contents start at zero and are never reset.
module data_mem
  import riscp_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [0:(1 << ADDR_W) - 1] = '{default: 32'h0000_0000};

  // Synchronous write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: ALU ops retire in one cycle, loads/stores
// occupy the memory for MEM_LATENCY cycles while upstream is stalled.
module mem_stage
  import riscp_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int MEM_LATENCY = MEM_LATENCY_DEF
) (
  input  logic        Clk_In,
  input  logic        Rst_In,
  mem_stage_if.slave  bus
);

  state_t            state;
  logic [7:0]        cnt;
  logic [31:0]       cap_inst;
  logic [31:0]       cap_result;
  logic [31:0]       cap_opb;
  logic [4:0]        cap_type;

  logic              commit;
  logic              misaligned;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rdata;

  // Commit decode; the write is suppressed when reset lands on the commit edge
  always_comb begin
    misaligned = (cap_result[1:0] != 2'b00);
    commit     = (state == ST_ACCESS) && (cnt == 8'd0);
    mem_addr   = cap_result[ADDR_W+1:2];
    mem_we     = commit && (cap_type == TYPE_STORE) && !misaligned && !Rst_In;
  end

  data_mem #(.ADDR_W(ADDR_W)) u_data_mem (
    .clk   (Clk_In),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (cap_opb),
    .rdata (mem_rdata)
  );

  assign bus.Stall_Out = (state == ST_ACCESS);

  // Stage FSM, latency counter, capture registers and registered outputs
  always_ff @(posedge Clk_In) begin
    if (Rst_In) begin
      state                 <= ST_IDLE;
      cnt                   <= 8'd0;
      cap_inst              <= 32'h0;
      cap_result            <= 32'h0;
      cap_opb               <= 32'h0;
      cap_type              <= 5'd0;
      bus.Valid_Out         <= 1'b0;
      bus.Inst_Out          <= 32'h0;
      bus.Inst_Type_Out     <= 5'd0;
      bus.Result_Out        <= 32'h0;
      bus.Load_Data_Out     <= 32'h0;
      bus.Rd_Out            <= 5'd0;
      bus.RegWrite_Out      <= 1'b0;
      bus.isBranchTaken_Out <= 1'b0;
      bus.Misaligned_Out    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!bus.Valid_In) begin
            bus.Valid_Out <= 1'b0;
          end else if (is_mem_type(bus.Inst_Type_In)) begin
            cap_inst      <= bus.Inst_In;
            cap_result    <= bus.Result_In;
            cap_opb       <= bus.Operand_B_In;
            cap_type      <= bus.Inst_Type_In;
            cnt           <= 8'(MEM_LATENCY - 1);
            state         <= ST_ACCESS;
            bus.Valid_Out <= 1'b0;
          end else begin
            bus.Valid_Out         <= 1'b1;
            bus.Inst_Out          <= bus.Inst_In;
            bus.Inst_Type_Out     <= bus.Inst_Type_In;
            bus.Result_Out        <= bus.Result_In;
            bus.Rd_Out            <= get_rd(bus.Inst_In);
            bus.Load_Data_Out     <= 32'h0;
            bus.Misaligned_Out    <= 1'b0;
            bus.RegWrite_Out      <= ((bus.Inst_Type_In == TYPE_IMMEDIATE) ||
                                      (bus.Inst_Type_In == TYPE_REG_REG)) &&
                                     (get_rd(bus.Inst_In) != 5'd0);
            bus.isBranchTaken_Out <= (bus.Inst_Type_In == TYPE_BRANCH) && bus.isBranchTaken_In;
          end
        end
        ST_ACCESS: begin
          if (commit) begin
            state                 <= ST_IDLE;
            bus.Valid_Out         <= 1'b1;
            bus.Inst_Out          <= cap_inst;
            bus.Inst_Type_Out     <= cap_type;
            bus.Result_Out        <= cap_result;
            bus.Rd_Out            <= get_rd(cap_inst);
            bus.isBranchTaken_Out <= 1'b0;
            bus.Misaligned_Out    <= misaligned;
            if ((cap_type == TYPE_LOAD) && !misaligned) begin
              bus.Load_Data_Out <= mem_rdata;
              bus.RegWrite_Out  <= (get_rd(cap_inst) != 5'd0);
            end else begin
              bus.Load_Data_Out <= 32'h0;
              bus.RegWrite_Out  <= 1'b0;
            end
          end else begin
            cnt           <= cnt - 8'd1;
            bus.Valid_Out <= 1'b0;
          end
        end
        default: begin
          state         <= ST_IDLE;
          bus.Valid_Out <= 1'b0;
        end
      endcase
    end
  end

endmodule
